// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_line_pkg;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN
    } dl_state_e;

    localparam int unsigned DL_MIN_DELAY = 1;

    // Width needed to hold any delay value 0..max_delay.
    function automatic int unsigned dl_dw(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Map a raw delay request onto the legal range 1..max_delay.
    function automatic int unsigned dl_clamp(input int unsigned sel,
                                             input int unsigned max_delay);
        if (sel < DL_MIN_DELAY) begin
            return DL_MIN_DELAY;
        end
        if (sel > max_delay) begin
            return max_delay;
        end
        return sel;
    endfunction

endpackage

// File: rtl/delay_line_stage.sv
// One delay-line stage: a resettable valid bit plus an unreset data register.
module delay_line_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Valid bit; clear_i kills the incoming beat (beyond active depth or flush).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i & ~clear_i;
        end
    end

    // Data payload; meaningless whenever valid_q is low, so no reset.
    always_ff @(posedge clk) begin
        data_q <= data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/delay_line_reg.sv
// Runtime-programmable fixed-latency delay line with drain-and-reload reprogramming.
module delay_line_reg
    import delay_line_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      MAX_DELAY = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     DW        = dl_dw(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [DW-1:0]    delay_sel,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [DW-1:0]    cur_delay
);

    dl_state_e        state_q, state_d;
    logic [DW-1:0]    cur_delay_q, cur_delay_d;
    logic [DW-1:0]    occ_q, occ_d;
    logic [DW-1:0]    req;
    logic             accept;

    logic [MAX_DELAY-1:0] stg_valid;
    logic [MAX_DELAY-1:0] stg_valid_in;
    logic [MAX_DELAY-1:0] stg_clear;
    logic [WIDTH-1:0]     stg_data    [MAX_DELAY];
    logic [WIDTH-1:0]     stg_data_in [MAX_DELAY];
    logic [WIDTH-1:0]     tap_data;

    // Clamped delay request.
    always_comb begin
        req = DW'(dl_clamp(32'(delay_sel), MAX_DELAY));
    end

    // Ready only in RUN with a stable request; kept apart from the FSM to avoid a
    // false loop through accept -> occupancy -> drain-done.
    always_comb begin
        in_ready = 1'b0;
        if (!flush && state_q == RUN) begin
            in_ready = (req == cur_delay_q);
        end
    end

    assign accept = in_valid & in_ready;

    // Shift chain; stages at or beyond the active depth never hold a valid beat.
    for (genvar i = 0; i < int'(MAX_DELAY); i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stg_valid_in[i] = accept;
            assign stg_data_in[i]  = in_data;
        end else begin : g_body
            assign stg_valid_in[i] = stg_valid[i-1];
            assign stg_data_in[i]  = stg_data[i-1];
        end
        assign stg_clear[i] = flush | (i >= int'(cur_delay_q));

        delay_line_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .valid_i (stg_valid_in[i]),
            .data_i  (stg_data_in[i]),
            .clear_i (stg_clear[i]),
            .valid_o (stg_valid[i]),
            .data_o  (stg_data[i])
        );
    end

    // Output tap at stage cur_delay-1.
    always_comb begin
        out_valid = 1'b0;
        tap_data  = stg_data[0];
        for (int unsigned i = 0; i < MAX_DELAY; i++) begin
            if (i == 32'(cur_delay_q) - 32'd1) begin
                out_valid = stg_valid[i];
                tap_data  = stg_data[i];
            end
        end
    end

    assign out_data  = out_valid ? tap_data : RESET_VAL;
    assign busy      = (occ_q != '0);
    assign cur_delay = cur_delay_q;

    // In-flight beat count: up on accept, down as the tap beat leaves.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !out_valid) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && out_valid) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // FSM next state; flush overrides everything and forces a reload.
    always_comb begin
        state_d     = state_q;
        cur_delay_d = cur_delay_q;
        if (flush) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD: begin
                    cur_delay_d = req;
                    state_d     = RUN;
                end
                RUN: begin
                    if (req != cur_delay_q) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // No shortcut back to RUN even if the request reverts.
                    if (occ_d == '0) begin
                        state_d = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            cur_delay_q <= DW'(MAX_DELAY);
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_delay_q <= cur_delay_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_delay_line_reg.sv
// Directed scoreboard bench for delay_line_reg (WIDTH=8, MAX_DELAY=8).
module tb_delay_line_reg;

    localparam logic [7:0] RV = 8'hEE;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] delay_sel;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic [3:0] cur_delay;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_delay = 3;

    delay_line_reg #(
        .WIDTH     (8),
        .MAX_DELAY (8),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .delay_sel (delay_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .cur_delay (cur_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every live cycle against the scoreboard front.
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_v;
            exp_t e;
            exp_v = (sb.size() != 0) && (sb[0].due <= cyc);
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                if (out_valid) check("out_data", 32'(out_data), 32'(e.data));
            end else if (!out_valid) begin
                check("out_data_idle", 32'(out_data), 32'(RV));
            end
        end
    end

    // Drive one beat; expected to be accepted at the coming edge.
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check("send_in_ready", 32'(in_ready), 32'd1);
        sb.push_back('{d, cyc + exp_delay});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reprogram(input logic [3:0] sel, input int exp);
        delay_sel = sel;
        @(negedge clk);
        check("reprog_ready_low", 32'(in_ready), 32'd0);
        wait_ready();
        check("reprog_cur_delay", 32'(cur_delay), 32'(exp));
        exp_delay = exp;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        check("busy_after_drain", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros;
        logic got;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; delay_sel = 4'd3; flush = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'(RV));
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cur_delay", 32'(cur_delay), 32'd8);
        @(negedge clk); @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("load_in_ready",  32'(in_ready),  32'd0);
        check("load_cur_delay", 32'(cur_delay), 32'd8);
        @(posedge clk); #1;
        check("run_cur_delay", 32'(cur_delay), 32'd3);
        check("run_in_ready",  32'(in_ready),  32'd1);
        exp_delay = 3;

        // Fixed delay 3.
        send(8'hA1); send(8'hA2); send(8'hA3);
        in_valid = 1'b0;
        check("fixed_busy", 32'(busy), 32'd1);
        drain();

        // Clamping: 0 -> 1, 12 -> 8.
        reprogram(4'd0, 1);
        send(8'h31); in_valid = 1'b0;
        drain();
        reprogram(4'd12, 8);
        send(8'h32); in_valid = 1'b0;
        drain();

        // Reprogram 3 -> 5 mid-stream with the producer holding a beat.
        reprogram(4'd3, 3);
        send(8'hB1); send(8'hB2); send(8'hB3);
        delay_sel = 4'd5;
        in_data   = 8'hB4;
        zeros = 0;
        got   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            zeros++;
        end
        // Change cycle + two drain cycles (B2, B3 at the tap) + one LOAD cycle.
        check("reprog_gap", 32'(zeros), 32'd4);
        check("reprog_new_delay", 32'(cur_delay), 32'd5);
        if (got) sb.push_back('{8'hB4, cyc + 5});
        @(posedge clk); #1;
        exp_delay = 5;
        send(8'hB5);
        in_valid = 1'b0;
        drain();

        // Flush discards two in-flight beats.
        reprogram(4'd4, 4);
        send(8'h11); send(8'h22);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy",     32'(busy),     32'd0);
        check("flush_load_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("flush_run_rdy",  32'(in_ready), 32'd1);
        check("flush_cur",      32'(cur_delay), 32'd4);
        repeat (8) @(posedge clk);
        #1;

        // Full depth: 16 back-to-back beats at delay 8.
        reprogram(4'd8, 8);
        for (int i = 0; i < 16; i++) begin
            send(8'hC0 + 8'(i));
        end
        in_valid = 1'b0;
        drain();

        // Async reset mid-stream while a beat is at the tap.
        for (int i = 0; i < 10; i++) begin
            send(8'hD0 + 8'(i));
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'(RV));
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_cur_delay", 32'(cur_delay), 32'd8);
        delay_sel = 4'd2;
        @(negedge clk); @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        wait_ready();
        check("post_rst_cur", 32'(cur_delay), 32'd2);
        exp_delay = 2;
        send(8'h77);
        in_valid = 1'b0;
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
